// File: rtl/rx_corr_readout_ctrl.sv
// rx_corr_readout_ctrl: peak tracking and drain sequencing for rx_correlator_buff
module rx_corr_readout_ctrl #(
    parameter int SAMPLE_W    = 32,
    parameter int SEQ_W       = 4,
    parameter int POST_WIN    = 100,
    parameter int READ_LEN    = 128,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                       crx_clk,
    input  logic                       rrx_rst,
    input  logic                       erx_en,
    input  logic                       inew_sample_trigger,
    input  logic signed [SAMPLE_W-1:0] ipeak_value,
    input  logic        [SEQ_W-1:0]    ipeak_seq,
    input  logic signed [SAMPLE_W-1:0] ithreshold,
    input  logic                       icorr_sample_ready,
    input  logic signed [SAMPLE_W-1:0] icorr_sample,
    output logic                       ostorage_wash_enable,
    output logic        [SEQ_W-1:0]    oreceived_seq,
    output logic                       onext_sample_trigger,
    output logic                       oall_acquired_trigg,
    output logic signed [SAMPLE_W-1:0] osample,
    output logic                       osample_valid,
    input  logic                       isample_ready,
    output logic                       obusy,
    output logic                       oerror
);
    localparam int WW = POST_WIN > 1 ? $clog2(POST_WIN) : 1;
    localparam int CW = $clog2(READ_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic signed [SAMPLE_W-1:0] PEAK_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
    typedef enum logic [2:0] {SEARCH, HOLD, WASH, DRAIN, DONE} state_t;
    state_t                     state;
    logic signed [SAMPLE_W-1:0] rpeak;
    logic        [SEQ_W-1:0]    rseq;
    logic        [WW-1:0]       win;
    logic        [CW-1:0]       ccnt, rcnt;
    logic        [TW-1:0]       tcnt;
    logic                       guard, xfer, capt, timeout, hit;
    assign obusy = state != SEARCH;
    always_comb begin
        xfer    = state == DRAIN && osample_valid && isample_ready;
        capt    = state == DRAIN && icorr_sample_ready && !guard && ccnt < CW'(READ_LEN)
                  && (!osample_valid || isample_ready);
        timeout = (state == WASH || state == DRAIN) && !icorr_sample_ready
                  && tcnt == TW'(TIMEOUT_CYC - 1);
        hit     = ipeak_value > (state == SEARCH ? ithreshold : rpeak);
    end
    always_ff @(posedge crx_clk) begin
        if (rrx_rst) begin
            state                <= SEARCH;
            rpeak                <= PEAK_MIN;
            rseq                 <= '0;
            win                  <= '0;
            ccnt                 <= '0;
            rcnt                 <= '0;
            tcnt                 <= '0;
            guard                <= 1'b0;
            ostorage_wash_enable <= 1'b0;
            oreceived_seq        <= '0;
            onext_sample_trigger <= 1'b0;
            oall_acquired_trigg  <= 1'b0;
            osample              <= '0;
            osample_valid        <= 1'b0;
            oerror               <= 1'b0;
        end else if (erx_en) begin
            onext_sample_trigger <= capt;
            oall_acquired_trigg  <= 1'b0;
            oerror               <= 1'b0;
            guard                <= capt;
            if (state == WASH || state == DRAIN)
                tcnt <= icorr_sample_ready ? '0 : tcnt + 1'b1;
            case (state)
                SEARCH: if (inew_sample_trigger && hit) begin
                    rpeak <= ipeak_value;
                    rseq  <= ipeak_seq;
                    win   <= '0;
                    state <= HOLD;
                end
                HOLD: if (inew_sample_trigger) begin
                    if (hit) begin
                        rpeak <= ipeak_value;
                        rseq  <= ipeak_seq;
                        win   <= '0;
                    end else if (win == WW'(POST_WIN - 1)) begin
                        state                <= WASH;
                        ostorage_wash_enable <= 1'b1;
                        oreceived_seq        <= rseq;
                        tcnt                 <= '0;
                        ccnt                 <= '0;
                        rcnt                 <= '0;
                    end else
                        win <= win + 1'b1;
                end
                WASH: if (icorr_sample_ready) state <= DRAIN;
                DRAIN: begin
                    if (capt) begin
                        osample       <= icorr_sample;
                        osample_valid <= 1'b1;
                        ccnt          <= ccnt + 1'b1;
                    end else if (xfer)
                        osample_valid <= 1'b0;
                    if (xfer) begin
                        rcnt <= rcnt + 1'b1;
                        if (rcnt == CW'(READ_LEN - 1)) begin
                            state                <= DONE;
                            osample_valid        <= 1'b0;
                            ostorage_wash_enable <= 1'b0;
                            oreceived_seq        <= '0;
                            oall_acquired_trigg  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= SEARCH;
                    rpeak <= PEAK_MIN;
                end
                default: state <= SEARCH;
            endcase
            // the buffer stopped answering: abandon this detection entirely
            if (timeout) begin
                state                <= SEARCH;
                rpeak                <= PEAK_MIN;
                tcnt                 <= '0;
                guard                <= 1'b0;
                osample_valid        <= 1'b0;
                ostorage_wash_enable <= 1'b0;
                oreceived_seq        <= '0;
                oerror               <= 1'b1;
                oall_acquired_trigg  <= 1'b1;
            end
        end
    end
endmodule
